// File: rtl/hub75_pixel_loader.sv
// rtl/hub75_pixel_loader.sv - raster pixel stream to HUB75 frame-buffer write port loader
//
// Purpose: accepts a raster-ordered {R,G,B} pixel stream with start-of-frame and
// end-of-line markers, checks it against the panel geometry and issues one registered
// frame-buffer write per accepted pixel. Marker mismatches pulse o_err_sync and the
// loader re-locks on the next start-of-frame.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   i_enable              1 = accept stream, 0 = pause (state frozen)
//   i_pix_valid/o_pix_ready  pixel handshake (ready is combinational)
//   i_pix_data            pixel {R,G,B}
//   i_pix_sof/i_pix_eol   frame start / line end markers
//   o_framebuf_wr_*       registered frame-buffer write (addr, data, strobe)
//   o_frame_done          pulse with the write of the last pixel of a frame
//   o_err_sync            pulse with the write of a beat whose markers mismatched

module hub75_pixel_loader #(
    parameter int hpixel_p = 64,
    parameter int vpixel_p = 64,
    parameter int bpp_p    = 8,
    localparam int frame_size_p = hpixel_p * vpixel_p,
    localparam int addr_width_p = $clog2(frame_size_p)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_enable,
    input  logic                    i_pix_valid,
    output logic                    o_pix_ready,
    input  logic [3*bpp_p-1:0]      i_pix_data,
    input  logic                    i_pix_sof,
    input  logic                    i_pix_eol,
    output logic [addr_width_p-1:0] o_framebuf_wr_addr,
    output logic [3*bpp_p-1:0]      o_framebuf_wr_data,
    output logic                    o_framebuf_wr_en,
    output logic                    o_frame_done,
    output logic                    o_err_sync
);

    localparam int XW = $clog2(hpixel_p);
    localparam int YW = (vpixel_p > 1) ? $clog2(vpixel_p) : 1;
    localparam int AW = addr_width_p;

    localparam logic [XW-1:0] X_LAST = XW'(hpixel_p - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(vpixel_p - 1);
    localparam logic [XW-1:0] X_ONE  = XW'(1);
    localparam logic [YW-1:0] Y_ONE  = YW'(1);
    localparam logic [AW-1:0] A_ONE  = AW'(1);

    typedef enum logic {
        WAIT_SOF = 1'b0,
        LOAD     = 1'b1
    } state_t;

    state_t             r_state;
    logic [XW-1:0]      r_x;
    logic [YW-1:0]      r_y;
    logic [AW-1:0]      r_addr;       // running y*hpixel_p + x, advanced by increment only
    logic [AW-1:0]      r_wr_addr;
    logic [3*bpp_p-1:0] r_wr_data;
    logic               r_wr_en;
    logic               r_frame_done;
    logic               r_err_sync;

    logic w_accept;
    logic w_last_col;
    logic w_last_row;

    assign o_pix_ready = i_enable & ~rst;
    assign w_accept    = i_pix_valid & o_pix_ready;
    assign w_last_col  = (r_x == X_LAST);
    assign w_last_row  = (r_y == Y_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= WAIT_SOF;
            r_x          <= '0;
            r_y          <= '0;
            r_addr       <= '0;
            r_wr_addr    <= '0;
            r_wr_data    <= '0;
            r_wr_en      <= 1'b0;
            r_frame_done <= 1'b0;
            r_err_sync   <= 1'b0;
        end else begin
            r_wr_en      <= 1'b0;
            r_frame_done <= 1'b0;
            r_err_sync   <= 1'b0;
            if (w_accept) begin
                if (i_pix_sof) begin
                    // SOF always (re)starts the frame at pixel (0,0). In LOAD it is a
                    // premature restart and flagged, but the beat still lands at addr 0.
                    r_wr_en    <= 1'b1;
                    r_wr_addr  <= '0;
                    r_wr_data  <= i_pix_data;
                    r_err_sync <= (r_state == LOAD) | i_pix_eol;
                    if (i_pix_eol) begin
                        // A line cannot end on its first pixel (hpixel_p >= 2).
                        r_x     <= '0;
                        r_y     <= '0;
                        r_addr  <= '0;
                        r_state <= WAIT_SOF;
                    end else begin
                        r_x     <= X_ONE;
                        r_y     <= '0;
                        r_addr  <= A_ONE;
                        r_state <= LOAD;
                    end
                end else if (r_state == LOAD) begin
                    r_wr_en   <= 1'b1;
                    r_wr_addr <= r_addr;
                    r_wr_data <= i_pix_data;
                    if (i_pix_eol != w_last_col) begin
                        r_err_sync <= 1'b1;
                        r_x        <= '0;
                        r_y        <= '0;
                        r_addr     <= '0;
                        r_state    <= WAIT_SOF;
                    end else if (w_last_col) begin
                        if (w_last_row) begin
                            r_frame_done <= 1'b1;
                            r_x          <= '0;
                            r_y          <= '0;
                            r_addr       <= '0;
                            r_state      <= WAIT_SOF;
                        end else begin
                            r_x    <= '0;
                            r_y    <= r_y + Y_ONE;
                            r_addr <= r_addr + A_ONE;
                        end
                    end else begin
                        r_x    <= r_x + X_ONE;
                        r_addr <= r_addr + A_ONE;
                    end
                end
                // WAIT_SOF with sof=0: beat is consumed and dropped silently.
            end
        end
    end

    assign o_framebuf_wr_addr = r_wr_addr;
    assign o_framebuf_wr_data = r_wr_data;
    assign o_framebuf_wr_en   = r_wr_en;
    assign o_frame_done       = r_frame_done;
    assign o_err_sync         = r_err_sync;

endmodule

// File: tb/tb_hub75_pixel_loader.sv
// tb/tb_hub75_pixel_loader.sv - scoreboard testbench for hub75_pixel_loader

module tb_hub75_pixel_loader;

    localparam int H  = 64;
    localparam int V  = 64;
    localparam int FS = H * V;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_enable;
    logic        i_pix_valid;
    logic        o_pix_ready;
    logic [23:0] i_pix_data;
    logic        i_pix_sof;
    logic        i_pix_eol;
    logic [11:0] o_framebuf_wr_addr;
    logic [23:0] o_framebuf_wr_data;
    logic        o_framebuf_wr_en;
    logic        o_frame_done;
    logic        o_err_sync;

    hub75_pixel_loader #(.hpixel_p(H), .vpixel_p(V), .bpp_p(8)) dut (
        .clk                (clk),
        .rst                (rst),
        .i_enable           (i_enable),
        .i_pix_valid        (i_pix_valid),
        .o_pix_ready        (o_pix_ready),
        .i_pix_data         (i_pix_data),
        .i_pix_sof          (i_pix_sof),
        .i_pix_eol          (i_pix_eol),
        .o_framebuf_wr_addr (o_framebuf_wr_addr),
        .o_framebuf_wr_data (o_framebuf_wr_data),
        .o_framebuf_wr_en   (o_framebuf_wr_en),
        .o_frame_done       (o_frame_done),
        .o_err_sync         (o_err_sync)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] addr;
        logic [23:0] data;
        logic        done;
        logic        err;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   writes_seen = 0;
    bit   mon_on = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [23:0] pd(input int t, input int i);
        return 24'((t << 16) ^ (i * 37) ^ 24'h00A500);
    endfunction

    task automatic expect_w(input int addr, input logic [23:0] d, input logic done, input logic err);
        exp_t e;
        e.addr = 12'(addr);
        e.data = d;
        e.done = done;
        e.err  = err;
        q.push_back(e);
    endtask

    // Monitor: every output event must match the head of the scoreboard queue.
    always @(negedge clk) begin
        if (mon_on && (o_framebuf_wr_en === 1'b1 || o_frame_done === 1'b1 || o_err_sync === 1'b1)) begin
            writes_seen++;
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: addr %0d data %0h done %0b err %0b, none expected",
                         o_framebuf_wr_addr, o_framebuf_wr_data, o_frame_done, o_err_sync);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("wr_en",   32'(o_framebuf_wr_en),   32'd1);
                chk("wr_addr", 32'(o_framebuf_wr_addr), 32'(e.addr));
                chk("wr_data", 32'(o_framebuf_wr_data), 32'(e.data));
                chk("frame_done", 32'(o_frame_done), 32'(e.done));
                chk("err_sync",   32'(o_err_sync),   32'(e.err));
            end
        end
    end

    task automatic beat(input logic [23:0] d, input logic s, input logic e);
        @(negedge clk);
        i_pix_valid = 1'b1;
        i_pix_data  = d;
        i_pix_sof   = s;
        i_pix_eol   = e;
        @(posedge clk);
        #1;
        i_pix_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            i_pix_valid = 1'b0;
        end
    endtask

    // Sends well-formed raster beats first..last of frame t, expecting one write each.
    // pause_at >= 0: stall with i_enable=0 for 20 cycles before that beat.
    task automatic frame(input int t, input int first, input int last, input bit gaps, input int pause_at);
        for (int i = first; i <= last; i++) begin
            if (gaps && ($urandom_range(0, 3) == 0)) idle($urandom_range(1, 3));
            if (i == pause_at) begin
                for (int k = 0; k < 20; k++) begin
                    @(negedge clk);
                    i_enable    = 1'b0;
                    i_pix_valid = 1'b1;
                    i_pix_data  = pd(t, i);
                    i_pix_sof   = 1'b0;
                    i_pix_eol   = 1'b0;
                    #1;
                    if (k == 0 || k == 19) chk("pause_ready", 32'(o_pix_ready), 32'd0);
                end
                @(negedge clk);
                i_enable    = 1'b1;
                i_pix_valid = 1'b0;
            end
            expect_w(i, pd(t, i), (i == FS - 1), 1'b0);
            beat(pd(t, i), (i == 0), ((i % H) == H - 1));
        end
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst         = 1'b1;
        i_enable    = 1'b1;
        i_pix_valid = 1'b0;
        i_pix_data  = '0;
        i_pix_sof   = 1'b0;
        i_pix_eol   = 1'b0;

        // Reset state
        @(posedge clk);
        @(negedge clk);
        chk("rst_ready", 32'(o_pix_ready), 32'd0);
        chk("rst_wr_en", 32'(o_framebuf_wr_en), 32'd0);
        chk("rst_addr",  32'(o_framebuf_wr_addr), 32'd0);
        chk("rst_data",  32'(o_framebuf_wr_data), 32'd0);
        chk("rst_flags", 32'({o_frame_done, o_err_sync}), 32'd0);
        rst = 1'b0;
        #1;
        chk("ready_after_rst", 32'(o_pix_ready), 32'd1);
        mon_on = 1'b1;

        // 1: full frame back-to-back
        frame(1, 0, FS - 1, 1'b0, -1);
        idle(3);

        // 2: five stray beats before a frame are dropped
        for (int i = 0; i < 5; i++) beat(pd(9, i), 1'b0, (i == 2));
        frame(2, 0, FS - 1, 1'b0, -1);
        idle(3);

        // 3: eol at row 3, x=10 -> addr 202 written with err, then beats dropped
        frame(3, 0, 201, 1'b0, -1);
        expect_w(202, pd(3, 202), 1'b0, 1'b1);
        beat(pd(3, 202), 1'b0, 1'b1);
        for (int i = 203; i < 206; i++) beat(pd(3, i), 1'b0, 1'b0);
        idle(3);

        // 4: premature sof after addr 999
        frame(4, 0, 999, 1'b0, -1);
        expect_w(0, pd(5, 0), 1'b0, 1'b1);
        beat(pd(5, 0), 1'b1, 1'b0);
        frame(5, 1, FS - 1, 1'b0, -1);
        idle(3);

        // 5: random gaps plus 20-cycle pause at row 2, x=30
        frame(6, 0, FS - 1, 1'b1, 2 * H + 30);
        idle(3);

        // 6: reset mid-frame after addr 1500
        frame(7, 0, 1500, 1'b0, -1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("midrst_wr_en", 32'(o_framebuf_wr_en), 32'd0);
        chk("midrst_addr",  32'(o_framebuf_wr_addr), 32'd0);
        chk("midrst_data",  32'(o_framebuf_wr_data), 32'd0);
        for (int i = 0; i < 4; i++) beat(pd(8, 100 + i), 1'b0, 1'b0);
        frame(8, 0, 70, 1'b0, -1);
        idle(4);

        chk("queue_drained", 32'(q.size()), 32'd0);
        chk("total_writes",  32'(writes_seen), 32'(FS * 4 + 203 + 1000 + 1501 + 71));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
